seg_display_driver: RTL
=======================

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 Parameter SCAN_DIV, default 50000, meaning clk cycles per digit-scan step (minimum 2).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 load  input  1  single-cycle strobe; captures data and mode.
REQ-006 mode  input  1  display format: 0 = hex, 1 = unsigned decimal.
REQ-007 data  input  32  value to display.
REQ-008 en  input  1  display enable; 0 blanks all digits.
REQ-009 busy  output  1  high while a decimal conversion is in progress.
REQ-010 seg  output  2x8  segment patterns per 4-digit group, active-high; bit0=a..bit6=g, bit7=dp.
REQ-011 seg_sel  output  2x4  one-hot digit select per group, active-high.

Function
REQ-012 The block SHALL hold eight 4-bit display digits D0 (least significant) to D7; group g, select bit i shows D(4g+i).
REQ-013 Hex load at cycle N SHALL set D7..D0 = data[31:0] nibbles at edge N+1; busy stays 0.
REQ-014 Decimal load at cycle N SHALL raise busy at edge N+1 and run a 32-step iterative double-dabble, one shift per cycle.
REQ-015 Decimal results SHALL commit to D7..D0 at edge N+33, with busy falling at the same edge.
REQ-016 Decimal data above 99_999_999 SHALL display overflow: D7 = "E", D6..D0 blank.
REQ-017 The block SHALL keep displaying the previous digits unchanged until a commit; there SHALL be no partial updates.
REQ-018 Load while busy SHALL abort the running conversion and restart with the new data/mode, last load wins.
REQ-019 Hex load while busy SHALL commit at the next edge and clear busy.
REQ-020 Leading-zero blanking SHALL apply in both modes: digits above the most significant non-zero digit show seg = 0; D0 is always shown.
REQ-021 A scan counter SHALL count 0..SCAN_DIV-1 and wrap.
REQ-022 On each scan-counter wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-023 seg_sel[g] SHALL equal one-hot(index) when en = 1 and 4'b0000 when en = 0.
REQ-024 seg[g] SHALL be the decoded pattern of D(4g+index), or 0 if that digit is blanked or en = 0.
REQ-025 Hex decode SHALL use standard 0-F patterns (b = 0x7C, d = 0x5E); "E" = 0x79; dp is always 0.
REQ-026 seg and seg_sel SHALL be registered: one-cycle latency from index or digit change to output.

Reset
REQ-027 rst SHALL asynchronously clear: D7..D0 = 0, scan counter = 0, index = 0, busy = 0, conversion state idle, seg = 0, seg_sel = 0.
REQ-028 After rst deasserts, the display SHALL show a single "0" on D0 (seg[0] = 0x3F when index = 0 and en = 1).
REQ-029 rst mid-conversion SHALL discard the conversion; no commit occurs.

Structure
REQ-030 A shared package seg_pkg SHALL hold NUM_DIGITS = 8, the segment pattern constants (0-F, E, blank), and the mode enum (MODE_HEX, MODE_DEC).
REQ-031 A sub-module bin2bcd SHALL implement the iterative double-dabble with a start/done handshake and an overflow flag.
REQ-032 Hex decode, blanking and scan logic SHALL stay in seg_display_driver.

Verification
REQ-033 Scenario: hex load of 0x1234ABCD, SCAN_DIV = 4, en = 1 -> D7..D0 = 1,2,3,4,A,B,C,D at N+1; a full scan shows seg[1] = 0x06,0x5B,0x4F,0x66 and seg[0] = 0x77,0x7C,0x39,0x5E over index 3..0.
REQ-034 Scenario: decimal load of 12345 -> busy high for exactly 32 cycles; commit at N+33 gives D4..D0 = 1,2,3,4,5 and D7..D5 blank.
REQ-035 Scenario: decimal load of 100_000_000 -> overflow display with D7 = 0x79 and all other digits 0x00.
REQ-036 Scenario: decimal load of 999, then hex load of 0x5 at N+10 -> busy falls at N+11, display shows "5", and 999 never appears.
REQ-037 Scenario: rst asserted at N+15 of a decimal conversion -> busy = 0, seg = 0 and seg_sel = 0 immediately; after release the display shows "0".
REQ-038 Scenario: en = 0 with data loaded -> seg_sel = 0 and seg = 0 for all indices; index keeps advancing.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display driver: digit count,
// segment patterns and the display mode encoding.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment patterns, active-high, bit0 = a .. bit6 = g, bit7 = dp (always 0)
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Maps one hex/BCD digit to its segment pattern
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] pattern;
    case (digit)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_E;
      default: pattern = SEG_F;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Iterative double-dabble: 32-bit binary to 8 BCD digits, one shift per
// clock. The final shifted value is presented combinationally together
// with done so the owner can commit on the same edge as the last shift.
module bin2bcd
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [31:0] bcd
);

  localparam logic [31:0] MAX_DEC = 32'd99_999_999;

  logic        running;
  logic [4:0]  step_cnt;
  logic [31:0] bin_sr;
  logic [31:0] bcd_sr;
  logic [31:0] adjusted;
  logic [31:0] bin_next;
  logic [31:0] bcd_next;
  logic        ovf_r;

  // Add-3 correction on every BCD digit of 5 or more before the shift
  always_comb begin
    adjusted = bcd_sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {bcd_next, bin_next} = {adjusted, bin_sr} << 1;

  assign busy     = running;
  assign done     = running && (step_cnt == 5'd31);
  assign overflow = ovf_r;
  assign bcd      = bcd_next;

  // Conversion sequencer: start (re)loads, abort cancels, else shift once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running  <= 1'b0;
      step_cnt <= '0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      ovf_r    <= 1'b0;
    end else if (start) begin
      running  <= 1'b1;
      step_cnt <= '0;
      bin_sr   <= bin;
      bcd_sr   <= '0;
      ovf_r    <= (bin > MAX_DEC);
    end else if (abort) begin
      running  <= 1'b0;
    end else if (running) begin
      bin_sr   <= bin_next;
      bcd_sr   <= bcd_next;
      step_cnt <= step_cnt + 5'd1;
      if (step_cnt == 5'd31) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed seven-segment driver: two groups of four digits
// scanned in parallel, hex or decimal display with leading-zero blanking.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            mode,
  input  logic [31:0]     data,
  input  logic            en,
  output logic            busy,
  output logic [1:0][7:0] seg,
  output logic [1:0][3:0] seg_sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  mode_e                      load_mode;
  logic                       conv_start;
  logic                       conv_abort;
  logic                       conv_done;
  logic                       conv_ovf;
  logic [31:0]                conv_bcd;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic                       ovf_disp;
  logic [NUM_DIGITS-1:0]      blank;
  logic                       upper_zero;
  logic [CNT_W-1:0]           scan_cnt;
  logic [1:0]                 index;
  logic [2:0]                 lo_idx;
  logic [2:0]                 hi_idx;

  assign load_mode  = mode_e'(mode);
  assign conv_start = load && (load_mode == MODE_DEC);
  assign conv_abort = load && (load_mode == MODE_HEX);

  bin2bcd u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (conv_start),
    .abort    (conv_abort),
    .bin      (data),
    .busy     (busy),
    .done     (conv_done),
    .overflow (conv_ovf),
    .bcd      (conv_bcd)
  );

  // Digit register: hex loads commit at once, decimal results commit whole
  // on the last conversion step unless a newer load supersedes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits   <= '0;
      ovf_disp <= 1'b0;
    end else if (conv_abort) begin
      digits   <= data;
      ovf_disp <= 1'b0;
    end else if (conv_done && !load) begin
      if (conv_ovf) begin
        digits   <= {4'hE, 28'h0};
        ovf_disp <= 1'b1;
      end else begin
        digits   <= conv_bcd;
        ovf_disp <= 1'b0;
      end
    end
  end

  // Blank every digit above the most significant non-zero one (D0 stays
  // lit); overflow lights only the "E" on D7
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    if (ovf_disp) begin
      blank = 8'h7F;
    end else begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        upper_zero = upper_zero && (digits[i] == 4'h0);
        blank[i]   = upper_zero;
      end
    end
  end

  // Scan timebase: advance the digit index once per SCAN_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      index    <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      index    <= index + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  assign lo_idx = {1'b0, index};
  assign hi_idx = {1'b1, index};

  // Registered segment and select outputs for both digit groups
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg     <= '0;
      seg_sel <= '0;
    end else if (en) begin
      seg_sel[0] <= 4'b0001 << index;
      seg_sel[1] <= 4'b0001 << index;
      seg[0]     <= blank[lo_idx] ? SEG_BLANK : seg_decode(digits[lo_idx]);
      seg[1]     <= blank[hi_idx] ? SEG_BLANK : seg_decode(digits[hi_idx]);
    end else begin
      seg     <= '0;
      seg_sel <= '0;
    end
  end

endmodule
